// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared constants for the RV32 pipeline control logic.
//   - RV32 base opcodes that matter to hazard detection
//   - controller FSM state encoding
//   - canonical NOP encoding (addi x0, x0, 0)
package pipeline_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [1:0] ST_RUN_ENC    = 2'd0;
    localparam logic [1:0] ST_DRAIN_ENC  = 2'd1;
    localparam logic [1:0] ST_HALTED_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN    = ST_RUN_ENC,
        ST_DRAIN  = ST_DRAIN_ENC,
        ST_HALTED = ST_HALTED_ENC
    } state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// hazard_detect: purely combinational RAW hazard check between the
// instruction in Dec and the producer in Exec.
// Ports:
//   instr_i        instruction in Dec
//   opcode_exec_i  opcode of the Exec instruction
//   rd_exec_i      destination register of the Exec instruction
//   wr_en_exec_i   Exec instruction writes the register file
//   hazard_o       Dec must hold for one cycle behind the Exec producer
module hazard_detect
    import pipeline_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic [6:0]  opcode_exec_i,
    input  logic [4:0]  rd_exec_i,
    input  logic        wr_en_exec_i,
    output logic        hazard_o
);

    logic [6:0] op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       dep;
    logic       unused_fields;

    assign op  = instr_i[6:0];
    assign rs1 = instr_i[19:15];
    assign rs2 = instr_i[24:20];

    // rd, funct3 and funct7 do not affect hazard detection.
    assign unused_fields = ^{instr_i[31:25], instr_i[14:7]};

    // The rs1 field of U-type and JAL is immediate bits, not a register.
    assign uses_rs1 = (op != OPC_LUI) && (op != OPC_AUIPC) && (op != OPC_JAL);
    assign uses_rs2 = (op == OPC_OP) || (op == OPC_STORE) || (op == OPC_BRANCH);

    assign dep = wr_en_exec_i && (rd_exec_i != 5'd0) &&
                 ((uses_rs1 && (rs1 == rd_exec_i)) ||
                  (uses_rs2 && (rs2 == rd_exec_i)));

    // Load data arrives too late for forwarding; branches and JALR resolve
    // in Dec and so cannot take an Exec result in the same cycle.
    assign hazard_o = dep && ((opcode_exec_i == OPC_LOAD) ||
                              (op == OPC_BRANCH) || (op == OPC_JALR));

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard, redirect and halt sequencer for the 5-stage pipe.
// Ports:
//   clk, rstn                   clock, async active-low reset
//   instr_Dec, opcode_Exec,
//   rd_Exec, wrEn_Exec          hazard inputs from Dec / Exec
//   npc_control                 taken branch/jump resolved in Dec
//   halt_IF, halt_WB            halt instruction seen in IF / reached WB
//   ext_stall                   external freeze (memory wait)
//   stall_IF, stall_Dec,
//   stall_all                   register hold enables (combinational)
//   flush_Dec, flush_IF         bubble insert enables (combinational)
//   halt_out, drain_timeout     registered halt status
//   state                       FSM state (0 RUN, 1 DRAIN, 2 HALTED)
//   cycle_cnt, stall_cnt,
//   flush_cnt                   saturating bring-up counters
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int DRAIN_MAX = 7
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [31:0]      instr_Dec,
    input  logic [6:0]       opcode_Exec,
    input  logic [4:0]       rd_Exec,
    input  logic             wrEn_Exec,
    input  logic             npc_control,
    input  logic             halt_IF,
    input  logic             halt_WB,
    input  logic             ext_stall,
    output logic             stall_IF,
    output logic             stall_Dec,
    output logic             stall_all,
    output logic             flush_Dec,
    output logic             flush_IF,
    output logic             halt_out,
    output logic             drain_timeout,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int DCW = (DRAIN_MAX < 1) ? 1 : $clog2(DRAIN_MAX + 1);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_MAX);

    state_e           state_q, state_d;
    logic [DCW-1:0]   drain_cnt_q, drain_cnt_d;
    logic             timeout_q, timeout_d;
    logic             halt_q;
    logic [CNT_W-1:0] cycle_cnt_q, stall_cnt_q, flush_cnt_q;
    logic             hazard;
    logic             in_run, in_drain, in_halted;

    hazard_detect u_hazard (
        .instr_i       (instr_Dec),
        .opcode_exec_i (opcode_Exec),
        .rd_exec_i     (rd_Exec),
        .wr_en_exec_i  (wrEn_Exec),
        .hazard_o      (hazard)
    );

    assign in_run    = (state_q == ST_RUN);
    assign in_drain  = (state_q == ST_DRAIN);
    assign in_halted = (state_q == ST_HALTED);

    // Priority: freeze beats hazard beats redirect.
    assign stall_all = ext_stall | in_halted;
    assign stall_IF  = hazard | in_drain | in_halted;
    assign stall_Dec = hazard;
    assign flush_Dec = hazard & ~stall_all;
    assign flush_IF  = npc_control & ~hazard & ~stall_all & in_run;

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        timeout_d   = timeout_q;
        unique case (state_q)
            ST_RUN: begin
                if (halt_IF) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = '0;
                end
            end
            ST_DRAIN: begin
                // drain_cnt keeps running under ext_stall so a stuck memory
                // cannot hold off the forced halt.
                if (halt_WB) begin
                    state_d = ST_HALTED;
                end else if (drain_cnt_q == DRAIN_LAST) begin
                    state_d   = ST_HALTED;
                    timeout_d = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            ST_HALTED: ;
            default: state_d = ST_RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= '0;
            timeout_q   <= 1'b0;
            halt_q      <= 1'b0;
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            timeout_q   <= timeout_d;
            halt_q      <= (state_d == ST_HALTED);
            if (!in_halted) begin
                if (cycle_cnt_q != '1)
                    cycle_cnt_q <= cycle_cnt_q + 1'b1;
                if ((stall_Dec | ext_stall) && (stall_cnt_q != '1))
                    stall_cnt_q <= stall_cnt_q + 1'b1;
                if (flush_IF && (flush_cnt_q != '1))
                    flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign state         = state_q;
    assign halt_out      = halt_q;
    assign drain_timeout = timeout_q;
    assign cycle_cnt     = cycle_cnt_q;
    assign stall_cnt     = stall_cnt_q;
    assign flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: self-checking bench for pipeline_ctrl. Expected control
// vectors are queued when stimulus is applied and popped when sampled;
// counters are tracked by a small saturating model.
module tb_pipeline_ctrl;
    import pipeline_pkg::*;

    localparam int CW = 5;
    localparam int DMAX = 7;

    localparam logic [31:0] ADD_X6_X5_X7 = {7'd0, 5'd7, 5'd5, 3'd0, 5'd6, 7'b0110011};
    localparam logic [31:0] LUI_X5       = {12'd0, 5'd5, 3'd0, 5'd5, 7'b0110111};
    localparam logic [31:0] BEQ_X5_X0    = {7'd0, 5'd0, 5'd5, 3'd0, 5'd0, 7'b1100011};

    logic          clk, rstn;
    logic [31:0]   instr_Dec;
    logic [6:0]    opcode_Exec;
    logic [4:0]    rd_Exec;
    logic          wrEn_Exec, npc_control, halt_IF, halt_WB, ext_stall;
    logic          stall_IF, stall_Dec, stall_all, flush_Dec, flush_IF;
    logic          halt_out, drain_timeout;
    logic [1:0]    state;
    logic [CW-1:0] cycle_cnt, stall_cnt, flush_cnt;

    pipeline_ctrl #(.CNT_W(CW), .DRAIN_MAX(DMAX)) dut (
        .clk(clk), .rstn(rstn), .instr_Dec(instr_Dec), .opcode_Exec(opcode_Exec),
        .rd_Exec(rd_Exec), .wrEn_Exec(wrEn_Exec), .npc_control(npc_control),
        .halt_IF(halt_IF), .halt_WB(halt_WB), .ext_stall(ext_stall),
        .stall_IF(stall_IF), .stall_Dec(stall_Dec), .stall_all(stall_all),
        .flush_Dec(flush_Dec), .flush_IF(flush_IF), .halt_out(halt_out),
        .drain_timeout(drain_timeout), .state(state), .cycle_cnt(cycle_cnt),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {stall_IF, stall_Dec, stall_all, flush_Dec, flush_IF}
    logic [4:0] ctl;
    assign ctl = {stall_IF, stall_Dec, stall_all, flush_Dec, flush_IF};

    typedef struct {
        string      name;
        logic [4:0] ctl;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;
    int   m_cyc = 0, m_stall = 0, m_flush = 0;

    function automatic logic [CW-1:0] satc(input int v);
        if (v >= (1 << CW) - 1) return '1;
        return CW'(v);
    endfunction

    task automatic idle_inputs();
        instr_Dec = 32'd0; opcode_Exec = 7'd0; rd_Exec = 5'd0; wrEn_Exec = 1'b0;
        npc_control = 1'b0; halt_IF = 1'b0; halt_WB = 1'b0; ext_stall = 1'b0;
    endtask

    // Advance one rising edge and update the counter model with what the
    // bench knows about that cycle.
    task automatic tick(input bit counting, input bit st, input bit fl);
        @(posedge clk);
        #1;
        if (counting) begin
            m_cyc++;
            if (st) m_stall++;
            if (fl) m_flush++;
        end
    endtask

    // Called at posedge+1; leaves the DUT out of reset at posedge+1.
    task automatic do_reset();
        idle_inputs();
        rstn = 1'b0;
        m_cyc = 0; m_stall = 0; m_flush = 0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rstn = 1'b0;
        #2;
        exp_q.push_back('{name: "reset_ctl", ctl: 5'b00000});
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
        checks++; if (halt_out !== 1'b0) begin errors++; $display("FAIL reset_halt_out: got %b want 0", halt_out); end
        checks++; if (drain_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", drain_timeout); end
        checks++; if ({cycle_cnt, stall_cnt, flush_cnt} !== '0) begin errors++;
            $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0", cycle_cnt, stall_cnt, flush_cnt); end
        e = exp_q.pop_front();
        checks++; if (ctl !== e.ctl) begin errors++; $display("FAIL %s: got %b want %b", e.name, ctl, e.ctl); end
        @(posedge clk);
        #1;
        checks++; if (cycle_cnt !== '0) begin errors++; $display("FAIL reset_hold_cycle: got %0d want 0", cycle_cnt); end
        rstn = 1'b1;
    endtask

    task automatic test_load_use();
        @(negedge clk);
        opcode_Exec = OPC_LOAD; rd_Exec = 5'd5; wrEn_Exec = 1'b1; instr_Dec = ADD_X6_X5_X7;
        exp_q.push_back('{name: "load_use", ctl: 5'b11010});
        #1; e = exp_q.pop_front();
        checks++; if (ctl !== e.ctl) begin errors++; $display("FAIL %s: got %b want %b", e.name, ctl, e.ctl); end
        checks++; if (stall_cnt !== satc(m_stall)) begin errors++; $display("FAIL load_use_stall_cnt_before: got %0d want %0d", stall_cnt, satc(m_stall)); end
        tick(1, 1, 0);
        checks++; if (stall_cnt !== satc(m_stall)) begin errors++; $display("FAIL load_use_stall_cnt: got %0d want %0d", stall_cnt, satc(m_stall)); end
        @(negedge clk);
        wrEn_Exec = 1'b0; opcode_Exec = 7'd0;  // bubble now in Exec
        exp_q.push_back('{name: "load_use_release", ctl: 5'b00000});
        #1; e = exp_q.pop_front();
        checks++; if (ctl !== e.ctl) begin errors++; $display("FAIL %s: got %b want %b", e.name, ctl, e.ctl); end
        tick(1, 0, 0);
        checks++; if (cycle_cnt !== satc(m_cyc)) begin errors++; $display("FAIL load_use_cycle_cnt: got %0d want %0d", cycle_cnt, satc(m_cyc)); end
    endtask

    task automatic test_no_false_hazard();
        @(negedge clk);
        opcode_Exec = OPC_LOAD; rd_Exec = 5'd0; wrEn_Exec = 1'b1; instr_Dec = {7'd0, 5'd0, 5'd0, 3'd0, 5'd6, OPC_OP};
        exp_q.push_back('{name: "rd_x0", ctl: 5'b00000});
        #1; e = exp_q.pop_front();
        checks++; if (ctl !== e.ctl) begin errors++; $display("FAIL %s: got %b want %b", e.name, ctl, e.ctl); end
        tick(1, 0, 0);
        @(negedge clk);
        rd_Exec = 5'd5; instr_Dec = LUI_X5;
        exp_q.push_back('{name: "lui_no_rs1", ctl: 5'b00000});
        #1; e = exp_q.pop_front();
        checks++; if (ctl !== e.ctl) begin errors++; $display("FAIL %s: got %b want %b", e.name, ctl, e.ctl); end
        tick(1, 0, 0);
        checks++; if (stall_cnt !== satc(m_stall)) begin errors++; $display("FAIL no_false_stall_cnt: got %0d want %0d", stall_cnt, satc(m_stall)); end
        idle_inputs();
    endtask

    task automatic test_ext_stall();
        @(negedge clk);
        opcode_Exec = OPC_LOAD; rd_Exec = 5'd5; wrEn_Exec = 1'b1; instr_Dec = ADD_X6_X5_X7;
        ext_stall = 1'b1; npc_control = 1'b1;
        exp_q.push_back('{name: "ext_stall_hazard", ctl: 5'b11100});
        #1; e = exp_q.pop_front();
        checks++; if (ctl !== e.ctl) begin errors++; $display("FAIL %s: got %b want %b", e.name, ctl, e.ctl); end
        tick(1, 1, 0);
        @(negedge clk);
        wrEn_Exec = 1'b0;
        exp_q.push_back('{name: "ext_stall_redirect", ctl: 5'b00100});
        #1; e = exp_q.pop_front();
        checks++; if (ctl !== e.ctl) begin errors++; $display("FAIL %s: got %b want %b", e.name, ctl, e.ctl); end
        tick(1, 1, 0);
        checks++; if ({stall_cnt, flush_cnt} !== {satc(m_stall), satc(m_flush)}) begin errors++;
            $display("FAIL ext_stall_counters: got %0d/%0d want %0d/%0d", stall_cnt, flush_cnt, satc(m_stall), satc(m_flush)); end
        idle_inputs();
    endtask

    task automatic test_branch_redirect();
        @(negedge clk);
        opcode_Exec = OPC_OP; rd_Exec = 5'd5; wrEn_Exec = 1'b1; instr_Dec = BEQ_X5_X0; npc_control = 1'b1;
        exp_q.push_back('{name: "branch_dep", ctl: 5'b11010});
        #1; e = exp_q.pop_front();
        checks++; if (ctl !== e.ctl) begin errors++; $display("FAIL %s: got %b want %b", e.name, ctl, e.ctl); end
        tick(1, 1, 0);
        @(negedge clk);
        wrEn_Exec = 1'b0;
        exp_q.push_back('{name: "branch_redirect", ctl: 5'b00001});
        #1; e = exp_q.pop_front();
        checks++; if (ctl !== e.ctl) begin errors++; $display("FAIL %s: got %b want %b", e.name, ctl, e.ctl); end
        tick(1, 0, 1);
        checks++; if (flush_cnt !== satc(m_flush)) begin errors++; $display("FAIL branch_flush_cnt: got %0d want %0d", flush_cnt, satc(m_flush)); end
        idle_inputs();
    endtask

    task automatic test_halt_drain();
        logic [CW-1:0] frozen;
        @(negedge clk);
        halt_IF = 1'b1; npc_control = 1'b1;
        exp_q.push_back('{name: "halt_with_redirect", ctl: 5'b00001});
        #1; e = exp_q.pop_front();
        checks++; if (ctl !== e.ctl) begin errors++; $display("FAIL %s: got %b want %b", e.name, ctl, e.ctl); end
        tick(1, 0, 1);
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL halt_enter_drain: got %0d want 1", state); end
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            halt_IF = 1'b1;  // re-seen halt in DRAIN must be ignored
            exp_q.push_back('{name: "drain_ctl", ctl: 5'b10000});
            #1; e = exp_q.pop_front();
            checks++; if (ctl !== e.ctl) begin errors++; $display("FAIL %s[%0d]: got %b want %b", e.name, i, ctl, e.ctl); end
            tick(1, 0, 0);
            checks++; if ({state, halt_out} !== {2'd1, 1'b0}) begin errors++;
                $display("FAIL drain_hold[%0d]: got state=%0d halt=%b want state=1 halt=0", i, state, halt_out); end
        end
        @(negedge clk);
        halt_IF = 1'b0; npc_control = 1'b0; halt_WB = 1'b1;
        tick(1, 0, 0);
        checks++; if ({state, halt_out, drain_timeout} !== {2'd2, 1'b1, 1'b0}) begin errors++;
            $display("FAIL halt_reached: got state=%0d halt=%b to=%b want state=2 halt=1 to=0", state, halt_out, drain_timeout); end
        exp_q.push_back('{name: "halted_ctl", ctl: 5'b10100});
        e = exp_q.pop_front();
        checks++; if (ctl !== e.ctl) begin errors++; $display("FAIL %s: got %b want %b", e.name, ctl, e.ctl); end
        checks++; if (cycle_cnt !== satc(m_cyc)) begin errors++; $display("FAIL halt_cycle_cnt: got %0d want %0d", cycle_cnt, satc(m_cyc)); end
        frozen = satc(m_cyc);
        halt_WB = 1'b0;
        tick(0, 0, 0);
        tick(0, 0, 0);
        checks++; if ({cycle_cnt, state, halt_out} !== {frozen, 2'd2, 1'b1}) begin errors++;
            $display("FAIL halted_frozen: got cyc=%0d state=%0d halt=%b want cyc=%0d state=2 halt=1", cycle_cnt, state, halt_out, frozen); end
    endtask

    task automatic test_drain_timeout();
        do_reset();
        @(negedge clk);
        halt_IF = 1'b1;
        tick(1, 0, 0);
        halt_IF = 1'b0;
        for (int i = 1; i <= DMAX; i++) begin
            tick(1, 0, 0);
            checks++; if ({state, halt_out, drain_timeout} !== {2'd1, 1'b0, 1'b0}) begin errors++;
                $display("FAIL timeout_drain[%0d]: got state=%0d halt=%b to=%b want 1/0/0", i, state, halt_out, drain_timeout); end
        end
        tick(1, 0, 0);
        checks++; if ({state, halt_out, drain_timeout} !== {2'd2, 1'b1, 1'b1}) begin errors++;
            $display("FAIL timeout_forced: got state=%0d halt=%b to=%b want 2/1/1", state, halt_out, drain_timeout); end
        checks++; if (cycle_cnt !== satc(m_cyc)) begin errors++; $display("FAIL timeout_cycle_cnt: got %0d want %0d", cycle_cnt, satc(m_cyc)); end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        @(negedge clk);
        opcode_Exec = OPC_LOAD; rd_Exec = 5'd5; wrEn_Exec = 1'b1; instr_Dec = ADD_X6_X5_X7;
        tick(1, 1, 0);
        @(negedge clk);
        idle_inputs(); npc_control = 1'b1; halt_IF = 1'b1;
        tick(1, 0, 1);
        idle_inputs();
        tick(1, 0, 0);
        checks++; if ({state, stall_cnt, flush_cnt} !== {2'd1, satc(m_stall), satc(m_flush)}) begin errors++;
            $display("FAIL pre_reset: got state=%0d st=%0d fl=%0d want 1/%0d/%0d", state, stall_cnt, flush_cnt, satc(m_stall), satc(m_flush)); end
        #3;
        rstn = 1'b0;  // mid-cycle, no clock edge before the check
        #1;
        m_cyc = 0; m_stall = 0; m_flush = 0;
        checks++; if ({state, halt_out, drain_timeout, cycle_cnt, stall_cnt, flush_cnt} !== '0) begin errors++;
            $display("FAIL async_reset: got state=%0d halt=%b to=%b cnt=%0d/%0d/%0d want all 0",
                     state, halt_out, drain_timeout, cycle_cnt, stall_cnt, flush_cnt); end
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_saturate();
        @(negedge clk);
        ext_stall = 1'b1;
        for (int i = 0; i < 40; i++) tick(1, 1, 0);
        checks++; if ({cycle_cnt, stall_cnt, flush_cnt} !== {satc(m_cyc), satc(m_stall), satc(m_flush)}) begin errors++;
            $display("FAIL saturate: got %0d/%0d/%0d want %0d/%0d/%0d", cycle_cnt, stall_cnt, flush_cnt,
                     satc(m_cyc), satc(m_stall), satc(m_flush)); end
        checks++; if (cycle_cnt !== {CW{1'b1}}) begin errors++; $display("FAIL saturate_all_ones: got %0d want %0d", cycle_cnt, (1 << CW) - 1); end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_false_hazard();
        test_ext_stall();
        test_branch_redirect();
        test_halt_drain();
        test_drain_timeout();
        test_reset_mid_drain();
        test_saturate();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard, redirect and halt sequencer for the 5-stage RV32 pipeline (IF, Dec, Exec, Mem, WB). It produces the stall and flush enables consumed by the top-level pipeline registers and the fetch stage. It drains the pipe cleanly on a halt and owns the halt output. It also keeps saturating cycle, stall and flush counters for bring-up.

## Interface
Parameters:
- CNT_W, 32, width of performance counters.
- DRAIN_MAX, 7, last DRAIN cycle index before forced halt; DRAIN lasts at most DRAIN_MAX+1 cycles.

Ports:
- clk  in  1  pipeline clock.
- rstn  in  1  reset; one clock, reset is asynchronous and active-low.
- instr_Dec  in  32  instruction currently in Dec.
- opcode_Exec  in  7  opcode of the instruction in Exec.
- rd_Exec  in  5  destination register of the instruction in Exec.
- wrEn_Exec  in  1  Exec instruction writes the register file.
- npc_control  in  1  Dec resolved a taken branch or jump this cycle.
- halt_IF  in  1  fetch detected the halt instruction.
- halt_WB  in  1  halt instruction is in WB.
- ext_stall  in  1  external freeze request (memory wait).
- stall_IF  out  1  hold PC and IF/Dec register.
- stall_Dec  out  1  hold Dec/Exec register.
- stall_all  out  1  freeze every pipeline register.
- flush_Dec  out  1  load a bubble (NOP, wrEn=0, mem_wEn=0) into Exec.
- flush_IF  out  1  replace Instruction_Dec with NOP on the next edge.
- halt_out  out  1  pipeline fully halted.
- drain_timeout  out  1  halt was forced without halt_WB.
- state  out  2  FSM state.
- cycle_cnt, stall_cnt, flush_cnt  out  CNT_W  counters.

## Operation
- Decode from instr_Dec: rs1=[19:15], rs2=[24:20], op=[6:0].
- uses_rs1: all opcodes except LUI 0110111, AUIPC 0010111 and JAL 1101111.
- uses_rs2: R 0110011, S 0100011 and B 1100011 only.
- dep: wrEn_Exec && rd_Exec!=0, and either (uses_rs1 && rs1==rd_Exec) or (uses_rs2 && rs2==rd_Exec).
- Hazard H = dep && (opcode_Exec==0000011 (load), or op is B 1100011 or JALR 1100111).
  - Load-use stalls one cycle.
  - Branches resolve in Dec, so they stall one cycle on any Exec producer.
- stall_all = ext_stall | (state==HALTED).
- stall_IF = H | (state==DRAIN) | (state==HALTED).
- stall_Dec = H.
- flush_Dec = H & ~stall_all.
- flush_IF = npc_control & ~H & ~stall_all & (state==RUN).
- Priority: stall_all > hazard > redirect.
- FSM, states 2'd0 RUN, 2'd1 DRAIN, 2'd2 HALTED:
  - RUN: halt_IF -> DRAIN, drain_cnt cleared to 0.
  - DRAIN: halt_WB -> HALTED. Otherwise, when drain_cnt==DRAIN_MAX -> HALTED and drain_timeout<=1. Otherwise drain_cnt+1.
  - HALTED: terminal until reset.
  - ext_stall does not pause drain_cnt.
- halt_out <= (next_state==HALTED).
- Counters, each saturating at all-ones; none counts in HALTED:
  - cycle_cnt: +1 every cycle in RUN or DRAIN.
  - stall_cnt: +1 when stall_Dec | ext_stall.
  - flush_cnt: +1 when flush_IF.

## Timing
- stall_*, flush_* are combinational from inputs and the state register, valid in the same cycle.
- state, halt_out, drain_timeout and counters are registered and update on the clk rising edge.
- halt_out rises on the edge where halt_WB is sampled high in DRAIN. With no external stall this is 4 edges after halt_IF.
- Reset (asynchronous, any state) forces:
  - state=RUN, halt_out=0, drain_timeout=0, drain_cnt=0, all counters 0.
  - With instr_Dec=0 there is no hazard, so stall/flush outputs are 0.
- halt_IF and npc_control in the same cycle: the redirect flush happens and the FSM enters DRAIN.
- halt_IF while already in DRAIN or HALTED is ignored.

## Structure
- pipeline_pkg holds:
  - opcode constants (LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, OP).
  - state encoding localparams.
  - the NOP encoding 32'h00000013.
- One combinational sub-module, hazard_detect, computes uses_rs1/uses_rs2 and H. The FSM, counters and output gating stay in pipeline_ctrl.

## Test plan
- Load-use: opcode_Exec=0000011, rd_Exec=5, wrEn_Exec=1, instr_Dec=add x6,x5,x7 -> stall_IF=stall_Dec=flush_Dec=1 for one cycle; stall_cnt 0->1.
- No false hazard: same case with rd_Exec=0, and separately with instr_Dec=lui x5 -> all stall/flush outputs 0.
- Branch dependency vs redirect:
  - beq x5,x0 in Dec with an ALU producer of x5 in Exec and npc_control=1 -> stall_Dec=1, flush_IF=0.
  - Next cycle, with no dep -> flush_IF=1 and flush_cnt +1.
- Halt drain: pulse halt_IF, then halt_WB 4 cycles later -> state 1 then 2, halt_out=1, stall_all=1, cycle_cnt frozen.
- Drain timeout: halt_IF with halt_WB held 0 -> HALTED after 8 DRAIN cycles, drain_timeout=1.
- Reset mid-operation: rstn low in DRAIN with counters nonzero -> state=0, halt_out=0 and counters 0 immediately, without a clock edge.
